nibbler_seq: RTL and testbench

NIBBLER_SEQ -- requirements
Module: nibbler_seq

---
 rtl/nibbler_seq_pkg.sv | 133 +++++++++++++
 rtl/nibbler_seq_wait.sv | 30 +++
 rtl/nibbler_seq.sv | 114 +++++++++++
 tb/tb_nibbler_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/nibbler_seq_pkg.sv
// Shared types and constants for the nibbler instruction sequencer.
// Holds the state and opcode enums, control-word bit positions and the
// EXEC-cycle control-word decode.
package nibbler_seq_pkg;

  localparam int unsigned CTRL_W = 16;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  typedef enum logic [OP_W-1:0] {
    OP_JC   = 4'h0,
    OP_JNC  = 4'h1,
    OP_CMPI = 4'h2,
    OP_CMPM = 4'h3,
    OP_LIT  = 4'h4,
    OP_IN   = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_JZ   = 4'h8,
    OP_JNZ  = 4'h9,
    OP_ADDI = 4'hA,
    OP_ADDM = 4'hB,
    OP_JMP  = 4'hC,
    OP_OUT  = 4'hD,
    OP_NORI = 4'hE,
    OP_NORM = 4'hF
  } opcode_t;

  // Control-word bit positions
  localparam int unsigned B_INC_PC   = 15;
  localparam int unsigned B_N_LOADPC = 14;
  localparam int unsigned B_LOAD_A   = 13;
  localparam int unsigned B_FLAGS_EN = 12;
  localparam int unsigned B_N_CIN    = 11;
  localparam int unsigned B_S_LSB    = 6;
  localparam int unsigned S_W        = 5;
  localparam int unsigned B_N_CS     = 5;
  localparam int unsigned B_N_WE     = 4;
  localparam int unsigned B_N_ALUBUS = 3;
  localparam int unsigned B_N_IN     = 2;
  localparam int unsigned B_N_OPER   = 1;
  localparam int unsigned B_N_OUT    = 0;

  // Quiescent word: PC held, all active-low enables deasserted
  localparam logic [CTRL_W-1:0] CTRL_IDLE = 16'h403F;

  // Bits cleared while a memory access is stalled so nothing commits early
  localparam logic [CTRL_W-1:0] WAIT_HOLD_MASK =
    ~((CTRL_W'(1) << B_INC_PC) | (CTRL_W'(1) << B_LOAD_A) | (CTRL_W'(1) << B_FLAGS_EN));

  // ALU function select codes
  localparam logic [S_W-1:0] ALU_SUB    = 5'b00110;
  localparam logic [S_W-1:0] ALU_PASS_B = 5'b01010;
  localparam logic [S_W-1:0] ALU_PASS_A = 5'b01111;
  localparam logic [S_W-1:0] ALU_ADD    = 5'b01001;
  localparam logic [S_W-1:0] ALU_NOR    = 5'b10001;

  // Opcodes that touch RAM and may stall on mem_ready
  function automatic logic is_mem_op(input opcode_t op);
    return op inside {OP_CMPM, OP_LD, OP_ST, OP_ADDM, OP_NORM};
  endfunction

  // Completing-cycle control word for each opcode, jump condition resolved
  function automatic logic [CTRL_W-1:0] exec_ctrl(input opcode_t op,
                                                  input logic carry,
                                                  input logic zero);
    logic [CTRL_W-1:0] w;
    logic              take;
    w           = CTRL_IDLE;
    w[B_INC_PC] = 1'b1;
    take        = 1'b0;
    case (op)
      OP_JC:   begin w[B_N_OPER] = 1'b0; take = carry;  end
      OP_JNC:  begin w[B_N_OPER] = 1'b0; take = ~carry; end
      OP_JZ:   begin w[B_N_OPER] = 1'b0; take = zero;   end
      OP_JNZ:  begin w[B_N_OPER] = 1'b0; take = ~zero;  end
      OP_JMP:  begin w[B_N_OPER] = 1'b0; take = 1'b1;   end
      OP_CMPI: begin
        w[B_FLAGS_EN] = 1'b1; w[B_S_LSB +: S_W] = ALU_SUB; w[B_N_OPER] = 1'b0;
      end
      OP_CMPM: begin
        w[B_FLAGS_EN] = 1'b1; w[B_S_LSB +: S_W] = ALU_SUB; w[B_N_CS] = 1'b0;
      end
      OP_LIT: begin
        w[B_LOAD_A] = 1'b1; w[B_S_LSB +: S_W] = ALU_PASS_B; w[B_N_OPER] = 1'b0;
      end
      OP_IN: begin
        w[B_LOAD_A] = 1'b1; w[B_S_LSB +: S_W] = ALU_PASS_B; w[B_N_IN] = 1'b0;
      end
      OP_LD: begin
        w[B_LOAD_A] = 1'b1; w[B_S_LSB +: S_W] = ALU_PASS_B; w[B_N_CS] = 1'b0;
      end
      OP_ST: begin
        w[B_S_LSB +: S_W] = ALU_PASS_A; w[B_N_CS] = 1'b0; w[B_N_WE] = 1'b0;
        w[B_N_ALUBUS] = 1'b0;
      end
      OP_ADDI: begin
        w[B_LOAD_A] = 1'b1; w[B_FLAGS_EN] = 1'b1; w[B_N_CIN] = 1'b1;
        w[B_S_LSB +: S_W] = ALU_ADD; w[B_N_OPER] = 1'b0;
      end
      OP_ADDM: begin
        w[B_LOAD_A] = 1'b1; w[B_FLAGS_EN] = 1'b1; w[B_N_CIN] = 1'b1;
        w[B_S_LSB +: S_W] = ALU_ADD; w[B_N_CS] = 1'b0;
      end
      OP_OUT: begin
        w[B_S_LSB +: S_W] = ALU_PASS_A; w[B_N_ALUBUS] = 1'b0; w[B_N_OUT] = 1'b0;
      end
      OP_NORI: begin
        w[B_LOAD_A] = 1'b1; w[B_FLAGS_EN] = 1'b1; w[B_N_CIN] = 1'b1;
        w[B_S_LSB +: S_W] = ALU_NOR; w[B_N_OPER] = 1'b0;
      end
      OP_NORM: begin
        w[B_LOAD_A] = 1'b1; w[B_FLAGS_EN] = 1'b1; w[B_N_CIN] = 1'b1;
        w[B_S_LSB +: S_W] = ALU_NOR; w[B_N_CS] = 1'b0;
      end
      default: ;
    endcase
    if (take) begin
      w[B_INC_PC]   = 1'b0;
      w[B_N_LOADPC] = 1'b0;
    end
    return w;
  endfunction

endpackage

// File: rtl/nibbler_seq_wait.sv
// Memory-wait cycle counter with timeout compare for nibbler_seq.
// Counter is held at zero outside WAIT, so it is cleared on every entry.
module nibbler_seq_wait
  import nibbler_seq_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic in_wait,
  input  logic mem_ready,
  output logic timeout_c
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + CNT_W'(1);

  // Count WAIT cycles; zero whenever the FSM is elsewhere
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cnt <= '0;
    else if (in_wait) cnt <= cnt_inc;
    else              cnt <= '0;
  end

  // Timeout when this WAIT cycle is the WAIT_MAX-th without a ready
  assign timeout_c = in_wait & ~mem_ready & (cnt_inc == CNT_W'(WAIT_MAX));

endmodule

// File: rtl/nibbler_seq.sv
// Nibbler instruction sequencer: IDLE/FETCH/EXEC/WAIT/HALT control FSM that
// emits the datapath control word for each fetched opcode.
// Optional feature macro: NIBBLER_SEQ_STEP_EN (single-step via step edge).
module nibbler_seq
  import nibbler_seq_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic [OP_W-1:0]   opcode,
  input  logic              carry,
  input  logic              zero,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrl,
  output logic              fetch_en,
  output logic              halted,
  output logic              err
);

  state_t            state;
  state_t            next_state;
  opcode_t           op;
  logic [CTRL_W-1:0] exec_word;
  logic              mem_stall_c;
  logic              in_wait_c;
  logic              wait_timeout_c;
  logic              step_rise_c;
  logic              stepped;
  state_t            done_state;

  assign op          = opcode_t'(opcode);
  assign exec_word   = exec_ctrl(op, carry, zero);
  assign mem_stall_c = is_mem_op(op) & ~mem_ready;
  assign in_wait_c   = (state == ST_WAIT);
  assign done_state  = (run && !stepped) ? ST_FETCH : ST_IDLE;

`ifdef NIBBLER_SEQ_STEP_EN
  logic step_q;

  // Step edge register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= step;
  end

  assign step_rise_c = step & ~step_q;

  // Remember whether the current instruction was launched by a step edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                             stepped <= 1'b0;
    else if (state == ST_IDLE && next_state == ST_FETCH)   stepped <= step_rise_c;
  end
`else
  logic unused_step;
  assign unused_step = step;
  assign step_rise_c = 1'b0;
  assign stepped     = 1'b0;
`endif

  nibbler_seq_wait #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait (
    .clk       (clk),
    .reset     (reset),
    .in_wait   (in_wait_c),
    .mem_ready (mem_ready),
    .timeout_c (wait_timeout_c)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (run || step_rise_c) next_state = ST_FETCH;
      ST_FETCH: next_state = ST_EXEC;
      ST_EXEC:  next_state = mem_stall_c ? ST_WAIT : done_state;
      ST_WAIT: begin
        if (mem_ready)           next_state = done_state;
        else if (wait_timeout_c) next_state = ST_HALT;
      end
      ST_HALT:  next_state = ST_HALT;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Output decode; stalled memory cycles hold the word with commits masked
  always_comb begin
    ctrl     = CTRL_IDLE;
    fetch_en = 1'b0;
    halted   = 1'b0;
    err      = 1'b0;
    case (state)
      ST_IDLE:  halted = 1'b1;
      ST_FETCH: fetch_en = 1'b1;
      ST_EXEC:  ctrl = mem_stall_c ? (exec_word & WAIT_HOLD_MASK) : exec_word;
      ST_WAIT:  ctrl = mem_ready ? exec_word : (exec_word & WAIT_HOLD_MASK);
      ST_HALT: begin
        halted = 1'b1;
        err    = 1'b1;
      end
      default:  halted = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_nibbler_seq.sv
// Directed, table-driven bench for nibbler_seq (instantiated with WAIT_MAX=4).
module tb_nibbler_seq;

  logic        clk;
  logic        reset;
  logic        run;
  logic        step;
  logic [3:0]  opcode;
  logic        carry;
  logic        zero;
  logic        mem_ready;
  logic [15:0] ctrl;
  logic        fetch_en;
  logic        halted;
  logic        err;

  int checks;
  int failures;

  localparam logic [15:0] IDLE_W = 16'h403F;

  typedef struct packed {
    logic [3:0]  op;
    logic        c;
    logic        z;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 22;
  vec_t vec [NV];

  nibbler_seq #(.WAIT_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .opcode    (opcode),
    .carry     (carry),
    .zero      (zero),
    .mem_ready (mem_ready),
    .ctrl      (ctrl),
    .fetch_en  (fetch_en),
    .halted    (halted),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    vec[0]  = '{4'h0, 1'b1, 1'b0, 16'h003D};  // JC taken
    vec[1]  = '{4'h0, 1'b0, 1'b0, 16'hC03D};  // JC not taken
    vec[2]  = '{4'h1, 1'b0, 1'b0, 16'h003D};  // JNC taken
    vec[3]  = '{4'h1, 1'b1, 1'b0, 16'hC03D};  // JNC not taken
    vec[4]  = '{4'h2, 1'b0, 1'b0, 16'hD1BD};  // CMPI
    vec[5]  = '{4'h3, 1'b0, 1'b0, 16'hD19F};  // CMPM
    vec[6]  = '{4'h4, 1'b0, 1'b0, 16'hE2BD};  // LIT
    vec[7]  = '{4'h5, 1'b0, 1'b0, 16'hE2BB};  // IN
    vec[8]  = '{4'h6, 1'b0, 1'b0, 16'hE29F};  // LD
    vec[9]  = '{4'h7, 1'b0, 1'b0, 16'hC3C7};  // ST
    vec[10] = '{4'h8, 1'b0, 1'b1, 16'h003D};  // JZ taken
    vec[11] = '{4'h8, 1'b1, 1'b0, 16'hC03D};  // JZ not taken, carry irrelevant
    vec[12] = '{4'h9, 1'b0, 1'b0, 16'h003D};  // JNZ taken
    vec[13] = '{4'h9, 1'b0, 1'b1, 16'hC03D};  // JNZ not taken
    vec[14] = '{4'hA, 1'b0, 1'b0, 16'hFA7D};  // ADDI
    vec[15] = '{4'hB, 1'b0, 1'b0, 16'hFA5F};  // ADDM
    vec[16] = '{4'hC, 1'b0, 1'b0, 16'h003D};  // JMP
    vec[17] = '{4'hD, 1'b0, 1'b0, 16'hC3F6};  // OUT
    vec[18] = '{4'hE, 1'b0, 1'b0, 16'hFC7D};  // NORI
    vec[19] = '{4'hF, 1'b0, 1'b0, 16'hFC5F};  // NORM
    vec[20] = '{4'hC, 1'b1, 1'b1, 16'h003D};  // JMP with flags set
    vec[21] = '{4'h1, 1'b1, 1'b1, 16'hC03D};  // JNC not taken, zero irrelevant

    // Reset state with run=1, LIT pending
    reset = 1'b1; run = 1'b1; step = 1'b0; opcode = 4'h4;
    carry = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    #12;
    check16("reset_ctrl", ctrl, IDLE_W);
    check1("reset_fetch_en", fetch_en, 1'b0);
    check1("reset_halted", halted, 1'b1);
    check1("reset_err", err, 1'b0);
    tick();
    reset = 1'b0;

    // LIT streaming: FETCH, EXEC, FETCH
    tick();
    check1("lit_c1_fetch_en", fetch_en, 1'b1);
    check16("lit_c1_ctrl", ctrl, IDLE_W);
    tick();
    check1("lit_c2_incpc", ctrl[15], 1'b1);
    check1("lit_c2_loada", ctrl[13], 1'b1);
    check1("lit_c2_fetch_en", fetch_en, 1'b0);
    tick();
    check1("lit_c3_fetch_en", fetch_en, 1'b1);
    run = 1'b0;
    tick();
    check16("lit_c4_exec", ctrl, 16'hE2BD);
    tick();
    check1("lit_run_drop_idle", halted, 1'b1);

    // Per-opcode EXEC control words
    for (int i = 0; i < NV; i++) begin
      opcode = vec[i].op; carry = vec[i].c; zero = vec[i].z;
      mem_ready = 1'b1; run = 1'b1;
      tick();
      check1($sformatf("vec%0d_fetch_en", i), fetch_en, 1'b1);
      run = 1'b0;
      tick();
      check16($sformatf("vec%0d_exec_ctrl", i), ctrl, vec[i].exp);
      tick();
      check1($sformatf("vec%0d_idle", i), halted, 1'b1);
    end

    // LD with three stalled WAIT cycles, completing on the fourth
    opcode = 4'h6; mem_ready = 1'b0; run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    check16("ld_exec_hold", ctrl, 16'h429F);
    for (int k = 1; k <= 3; k++) begin
      tick();
      check16($sformatf("ld_wait%0d_hold", k), ctrl, 16'h429F);
      check1($sformatf("ld_wait%0d_halted", k), halted, 1'b0);
    end
    tick();
    mem_ready = 1'b1;
    #1;
    check16("ld_wait4_complete", ctrl, 16'hE29F);
    tick();
    check1("ld_done_idle", halted, 1'b1);
    check1("ld_done_err", err, 1'b0);

    // Asynchronous reset during WAIT
    opcode = 4'h6; mem_ready = 1'b0; run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    check16("rstw_wait_ctrl", ctrl, 16'h429F);
    #2;
    reset = 1'b1;
    #1;
    check16("rstw_ctrl_async", ctrl, IDLE_W);
    check1("rstw_halted_async", halted, 1'b1);
    tick();
    check1("rstw_fetch_en", fetch_en, 1'b0);
    reset = 1'b0; mem_ready = 1'b1;
    tick();
    check1("rstw_after_idle", halted, 1'b1);

`ifdef NIBBLER_SEQ_STEP_EN
    // Single step: one FETCH/EXEC, second pulse in EXEC ignored
    opcode = 4'hA; run = 1'b0; step = 1'b1;
    tick();
    check1("step_fetch_en", fetch_en, 1'b1);
    step = 1'b0;
    tick();
    check16("step_exec", ctrl, 16'hFA7D);
    step = 1'b1;
    tick();
    check1("step_idle", halted, 1'b1);
    tick();
    check1("step_not_queued", fetch_en, 1'b0);
    check1("step_still_idle", halted, 1'b1);
    step = 1'b0;
    tick();
`else
    // Step has no effect without the feature
    opcode = 4'hA; run = 1'b0; step = 1'b1;
    tick();
    check1("step_ignored_fetch", fetch_en, 1'b0);
    step = 1'b0;
    tick();
    check1("step_ignored_idle", halted, 1'b1);
`endif

    // ST timeout after WAIT_MAX=4 WAIT cycles, HALT sticky until reset
    opcode = 4'h7; mem_ready = 1'b0; run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    check16("st_exec_hold", ctrl, 16'h43C7);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check16($sformatf("st_wait%0d_hold", k), ctrl, 16'h43C7);
      check1($sformatf("st_wait%0d_err", k), err, 1'b0);
    end
    tick();
    check1("halt_err", err, 1'b1);
    check1("halt_halted", halted, 1'b1);
    check16("halt_ctrl", ctrl, IDLE_W);
    mem_ready = 1'b1; run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check1($sformatf("halt_sticky%0d", k), err, 1'b1);
      check1($sformatf("halt_nofetch%0d", k), fetch_en, 1'b0);
    end
    run = 1'b0;
    reset = 1'b1;
    #1;
    check1("halt_reset_err", err, 1'b0);
    check1("halt_reset_halted", halted, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    check16("final_idle_ctrl", ctrl, IDLE_W);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
